// File: rtl/mem_responder.sv
// Word-organised data store behind a fixed-latency request/response handshake.
// Sub-word accesses use little-endian byte lanes; faults complete with err and no store access.
module mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        capture;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic        sext_q, rd_q, wr_q;

    logic [31:0]      mem_q [DEPTH];
    logic [IDX_W-1:0] idx;
    logic             fault;
    logic             do_write;
    logic [3:0]       be;
    logic [31:0]      wd_al;

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] a,
                                                 input logic [1:0] sz, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = word[{a[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   return sx ? {{24{b[7]}}, b} : {24'b0, b};
            2'b01:   return sx ? {{16{h[15]}}, h} : {16'b0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_align(input logic [31:0] d, input logic [1:0] sz);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    capture = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESPOND;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESPOND;
                else               cnt_d = cnt_q - 4'd1;
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                size_q  <= size;
                sext_q  <= sign_ext;
                rd_q    <= mem_read;
                wr_q    <= mem_write;
            end
        end
    end

    // Both strobes together is treated as a malformed request, same as a bad address.
    assign fault = (rd_q && wr_q) || (size_q == 2'b11) ||
                   (size_q == 2'b01 && addr_q[0]) ||
                   (size_q == 2'b10 && addr_q[1:0] != 2'b00) ||
                   ({2'b00, addr_q[31:2]} >= 32'(DEPTH));

    assign idx      = addr_q[IDX_W+1:2];
    assign be       = lane_enables(addr_q[1:0], size_q);
    assign wd_al    = store_align(wdata_q, size_q);
    assign do_write = (state_q == S_RESPOND) && wr_q && !fault && !reset;

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= wd_al[8*i +: 8];
            end
        end
    end

    assign ready = (state_q == S_RESPOND);
    assign busy  = (state_q != S_IDLE);
    assign err   = ready && fault;
    assign rdata = (ready && rd_q && !fault) ?
                   load_extract(mem_q[idx], addr_q[1:0], size_q, sext_q) : 32'd0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: two instances (WAIT_STATES=2 and 0); monitors pop expected responses on ready.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, sign_ext;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic [31:0] rdata;
    logic        ready, busy, err;

    logic        m0_read, m0_write, m0_sext;
    logic [31:0] m0_addr, m0_wdata;
    logic [1:0]  m0_size;
    logic [31:0] rdata0;
    logic        ready0, busy0, err0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.DEPTH(256), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .size(size), .sign_ext(sign_ext),
        .rdata(rdata), .ready(ready), .busy(busy), .err(err)
    );

    mem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .mem_read(m0_read), .mem_write(m0_write),
        .addr(m0_addr), .wdata(m0_wdata), .size(m0_size), .sign_ext(m0_sext),
        .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ready) begin
                if (q2.size() == 0) begin
                    chk("ws2_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q2.pop_front();
                    chk("ws2_rdata", rdata, e.rdata);
                    chk("ws2_err", {31'd0, err}, {31'd0, e.err});
                    chk("ws2_ready_cycle", cyc, e.cyc);
                end
            end else begin
                chk("ws2_idle_rdata", rdata, 32'd0);
                chk("ws2_idle_err", {31'd0, err}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (ready0) begin
                if (q0.size() == 0) begin
                    chk("ws0_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("ws0_rdata", rdata0, e.rdata);
                    chk("ws0_err", {31'd0, err0}, {31'd0, e.err});
                    chk("ws0_ready_cycle", cyc, e.cyc);
                end
            end else begin
                chk("ws0_idle_rdata", rdata0, 32'd0);
                chk("ws0_idle_err", {31'd0, err0}, 32'd0);
            end
        end
    end

    // Called at posedge+1 with the WAIT_STATES=2 instance idle; returns one cycle after ready.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sx,
                         input logic [31:0] er, input logic ee);
        exp_t e;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        size      = sz;
        sign_ext  = sx;
        e.rdata = er;
        e.err   = ee;
        e.cyc   = cyc + 3;
        q2.push_back(e);
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        chk("ws2_busy_after_capture", {31'd0, busy}, 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0; size = '0; sign_ext = 1'b0;
        m0_read = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0; m0_size = '0; m0_sext = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_busy0", {31'd0, busy0}, 32'd0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 1'b1, 32'h11, 32'h00000080, 2'b00, 1'b0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h11, 32'h0, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0);
        issue(1'b1, 1'b0, 32'h11, 32'h0, 2'b00, 1'b0, 32'h00000080, 1'b0);

        issue(1'b1, 1'b0, 32'h13, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 32'h402, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
        issue(1'b1, 1'b1, 32'h10, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
        issue(1'b0, 1'b1, 32'h11, 32'h1234, 2'b01, 1'b0, 32'h0, 1'b1);

        issue(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD80EF, 1'b0);
        issue(1'b1, 1'b0, 32'h12, 32'h0, 2'b01, 1'b1, 32'hFFFFDEAD, 1'b0);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 2'b01, 1'b0, 32'h000080EF, 1'b0);
        issue(1'b1, 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 32'hFFFFFFDE, 1'b0);

        // Second write strobe while the first is in flight must be ignored.
        issue(1'b0, 1'b1, 32'h24, 32'h33333333, 2'b10, 1'b0, 32'h0, 1'b0);
        mem_write = 1'b1; addr = 32'h20; wdata = 32'h11111111; size = 2'b10;
        e.rdata = 32'h0; e.err = 1'b0; e.cyc = cyc + 3;
        q2.push_back(e);
        @(posedge clk); #1;
        addr = 32'h24; wdata = 32'h22222222;
        @(posedge clk); #1;
        mem_write = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        issue(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h11111111, 1'b0);
        issue(1'b1, 1'b0, 32'h24, 32'h0, 2'b10, 1'b0, 32'h33333333, 1'b0);

        // Reset in WAIT aborts the write: no ready and no store update.
        mem_write = 1'b1; addr = 32'h20; wdata = 32'h55555555; size = 2'b10;
        @(posedge clk); #1;
        mem_write = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        issue(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h11111111, 1'b0);

        issue(1'b0, 1'b1, 32'h23, 32'h000000AB, 2'b00, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 32'h20, 32'h0000BEEF, 2'b01, 1'b0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hAB11BEEF, 1'b0);

        // Zero wait states with the write strobe held: captures every second cycle.
        m0_write = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h12345678; m0_size = 2'b10;
        for (int k = 0; k < 3; k++) begin
            e.rdata = 32'h0; e.err = 1'b0; e.cyc = cyc + 2*k + 1;
            q0.push_back(e);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("ws0_busy_pattern", {31'd0, busy0}, (k % 2 == 1) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        m0_write = 1'b0;
        m0_read  = 1'b1;
        e.rdata = 32'h12345678; e.err = 1'b0; e.cyc = cyc + 1;
        q0.push_back(e);
        @(posedge clk); #1;
        m0_read = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end

        chk("ws2_pending_responses", q2.size(), 32'd0);
        chk("ws0_pending_responses", q0.size(), 32'd0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
